curve_param_ctrl: RTL and testbench

Per-frame statistics and curve-parameter scheduler for the brightness dynamic-curve pipeline. It sits directly after the RGB-to-gray stage and consumes the gray pixel stream and its delayed sync signals. Per frame it accumulates luma sum and dark-pixel count, then at each frame boundary runs a shared serial divider twice to obtain mean luma and dark ratio. It selects a curve index and hands the parameter set to the curve/LUT stage over a valid/ready handshake.

---
 rtl/curve_pkg.sv | 33 +++
 rtl/curve_param_ctrl_serial_div.sv | 66 ++++++
 rtl/curve_param_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_curve_param_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/curve_pkg.sv
// Shared FSM state type, counter widths and curve-selection thresholds
// for the brightness curve parameter scheduler.
package curve_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DIV_MEAN,
      ST_DIV_DARK,
      ST_DECIDE,
      ST_OUT
   } state_t;

   localparam int PIX_W = 22;
   localparam int SUM_W = 30;

   localparam logic [7:0] TH_MEAN_STRONG = 8'd64;
   localparam logic [7:0] TH_MEAN_MID    = 8'd96;
   localparam logic [7:0] TH_MEAN_MILD   = 8'd160;
   localparam logic [7:0] TH_RATIO_DARK  = 8'd128;

   // Priority order matters: the dark-lift test must win over the mean-only tests.
   function automatic logic [1:0] select_curve(input logic [7:0] mean,
                                               input logic [7:0] ratio);
      logic [1:0] sel;
      if (mean < TH_MEAN_STRONG && ratio >= TH_RATIO_DARK) sel = 2'd3;
      else if (mean < TH_MEAN_MID)                         sel = 2'd2;
      else if (mean < TH_MEAN_MILD)                        sel = 2'd1;
      else                                                 sel = 2'd0;
      return sel;
   endfunction

endpackage

// File: rtl/curve_param_ctrl_serial_div.sv
// Restoring serial divider, one quotient bit per cycle, DIV_W cycles per
// division. o_quot/o_done present the final quotient during the last step.
module serial_div #(
   parameter int DIV_W  = 32,
   parameter int DVSR_W = 22
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [DIV_W-1:0]  i_dividend,
   input  logic [DVSR_W-1:0] i_divisor,
   output logic              o_busy,
   output logic              o_done,
   output logic [DIV_W-1:0]  o_quot
);

   localparam int CNT_W = $clog2(DIV_W);

   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;
   logic [DIV_W-1:0]  r_q;
   logic [DVSR_W-1:0] r_rem;
   logic [DVSR_W-1:0] r_dvsr;

   logic [DVSR_W:0]   w_rem_sh;
   logic [DVSR_W:0]   w_rem_nxt;
   logic              w_ge;
   logic [DIV_W-1:0]  w_q_nxt;
   logic              w_unused_rem;

   always_comb begin
      w_rem_sh  = {r_rem, r_q[DIV_W-1]};
      w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
      w_rem_nxt = w_ge ? (w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh;
      w_q_nxt   = {r_q[DIV_W-2:0], w_ge};
   end

   // Remainder stays below the divisor, so its top bit is always zero.
   assign w_unused_rem = w_rem_nxt[DVSR_W];

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == '0);
   assign o_quot = w_q_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_q    <= '0;
         r_rem  <= '0;
         r_dvsr <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CNT_W'(DIV_W - 1);
         r_q    <= i_dividend;
         r_rem  <= '0;
         r_dvsr <= i_divisor;
      end else if (r_busy) begin
         r_q   <= w_q_nxt;
         r_rem <= w_rem_nxt[DVSR_W-1:0];
         if (r_cnt == '0) r_busy <= 1'b0;
         else             r_cnt  <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/curve_param_ctrl.sv
// Per-frame luma/dark statistics and curve parameter scheduler; hands the
// chosen curve parameters downstream over a valid/ready handshake.
module curve_param_ctrl
   import curve_pkg::*;
#(
   parameter int IMG_W   = 1920,
   parameter int IMG_H   = 1080,
   parameter int DARK_TH = 64,
   parameter int DIV_W   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gray_v,
   input  logic       gray_h,
   input  logic       gray_de,
   input  logic [7:0] gray,
   input  logic       param_ready,
   output logic       param_valid,
   output logic [7:0] frame_mean,
   output logic [7:0] dark_ratio,
   output logic [1:0] curve_sel,
   output logic       frame_err,
   output logic       frame_drop
);

   localparam logic [PIX_W-1:0] LP_FRAME_PIX = PIX_W'(IMG_W * IMG_H);
   localparam logic [8:0]       LP_DARK_TH   = 9'(DARK_TH);

   state_t r_state, w_state_nxt;

   logic             r_v_d;
   logic             w_rise;
   logic             w_is_dark;
   logic [PIX_W-1:0] r_pix_cnt;
   logic [SUM_W-1:0] r_luma_sum;
   logic [PIX_W-1:0] r_dark_cnt;
   logic [PIX_W-1:0] r_snap_pix;
   logic [PIX_W-1:0] r_snap_dark;
   logic [7:0]       r_mean;
   logic [7:0]       r_ratio;

   logic             w_snap_en;
   logic             w_err_set;
   logic             w_drop_set;
   logic             w_mean_en;
   logic             w_ratio_en;
   logic             w_decide;
   logic             w_accept;

   logic             w_div_start;
   logic [DIV_W-1:0] w_div_dividend;
   logic [PIX_W-1:0] w_div_divisor;
   logic             w_div_busy;
   logic             w_div_done;
   logic [DIV_W-1:0] w_div_quot;
   logic [7:0]       w_quot_sat;
   logic             w_unused_in;

   assign w_rise      = gray_v & ~r_v_d;
   assign w_is_dark   = ({1'b0, gray} < LP_DARK_TH);
   assign w_quot_sat  = (|w_div_quot[DIV_W-1:8]) ? 8'hFF : w_div_quot[7:0];
   assign w_unused_in = gray_h ^ w_div_busy;

   // A sample coincident with the rise starts the new frame's totals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v_d      <= 1'b0;
         r_pix_cnt  <= '0;
         r_luma_sum <= '0;
         r_dark_cnt <= '0;
      end else begin
         r_v_d <= gray_v;
         if (w_rise) begin
            r_pix_cnt  <= PIX_W'(gray_de);
            r_luma_sum <= gray_de ? SUM_W'(gray) : '0;
            r_dark_cnt <= PIX_W'(gray_de & w_is_dark);
         end else if (gray_de) begin
            r_pix_cnt  <= r_pix_cnt + 1'b1;
            r_luma_sum <= r_luma_sum + SUM_W'(gray);
            r_dark_cnt <= r_dark_cnt + PIX_W'(w_is_dark);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // The mean pass starts straight from the live accumulators at the rise;
   // the divider's own operand latch serves as the luma-sum snapshot.
   always_comb begin
      w_state_nxt    = r_state;
      w_snap_en      = 1'b0;
      w_err_set      = 1'b0;
      w_drop_set     = 1'b0;
      w_mean_en      = 1'b0;
      w_ratio_en     = 1'b0;
      w_decide       = 1'b0;
      w_accept       = 1'b0;
      w_div_start    = 1'b0;
      w_div_dividend = DIV_W'(r_luma_sum);
      w_div_divisor  = r_pix_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) w_state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (w_rise && (r_pix_cnt != '0)) begin
               w_snap_en   = 1'b1;
               w_div_start = 1'b1;
               w_err_set   = (r_pix_cnt != LP_FRAME_PIX);
               w_state_nxt = ST_DIV_MEAN;
            end
         end
         ST_DIV_MEAN: begin
            w_drop_set     = w_rise;
            w_div_dividend = DIV_W'({r_snap_dark, 8'b0});
            w_div_divisor  = r_snap_pix;
            if (w_div_done) begin
               w_mean_en   = 1'b1;
               w_div_start = 1'b1;
               w_state_nxt = ST_DIV_DARK;
            end
         end
         ST_DIV_DARK: begin
            w_drop_set = w_rise;
            if (w_div_done) begin
               w_ratio_en  = 1'b1;
               w_state_nxt = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            w_drop_set  = w_rise;
            w_decide    = 1'b1;
            w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            w_drop_set = w_rise;
            if (param_valid && param_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap_pix  <= '0;
         r_snap_dark <= '0;
         r_mean      <= '0;
         r_ratio     <= '0;
         param_valid <= 1'b0;
         frame_mean  <= '0;
         dark_ratio  <= '0;
         curve_sel   <= '0;
         frame_err   <= 1'b0;
         frame_drop  <= 1'b0;
      end else begin
         frame_err  <= w_err_set;
         frame_drop <= w_drop_set;
         if (w_snap_en) begin
            r_snap_pix  <= r_pix_cnt;
            r_snap_dark <= r_dark_cnt;
         end
         if (w_mean_en)  r_mean  <= w_quot_sat;
         if (w_ratio_en) r_ratio <= w_quot_sat;
         if (w_decide) begin
            frame_mean  <= r_mean;
            dark_ratio  <= r_ratio;
            curve_sel   <= select_curve(r_mean, r_ratio);
            param_valid <= 1'b1;
         end else if (w_accept) begin
            param_valid <= 1'b0;
         end
      end
   end

   serial_div #(
      .DIV_W  (DIV_W),
      .DVSR_W (PIX_W)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_div_start),
      .i_dividend (w_div_dividend),
      .i_divisor  (w_div_divisor),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quot     (w_div_quot)
   );

endmodule

// File: tb/tb_curve_param_ctrl.sv
// Bench for curve_param_ctrl: directed and randomized frames checked against
// a frame-level arithmetic model of mean, dark ratio and curve choice.
module tb_curve_param_ctrl;

   localparam int IMG_W     = 8;
   localparam int IMG_H     = 4;
   localparam int DARK_TH   = 64;
   localparam int DIV_W     = 32;
   localparam int FRAME_PIX = IMG_W * IMG_H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gray_v = 1'b0;
   logic       gray_h = 1'b0;
   logic       gray_de = 1'b0;
   logic [7:0] gray = 8'd0;
   logic       param_ready = 1'b0;
   logic       param_valid;
   logic [7:0] frame_mean;
   logic [7:0] dark_ratio;
   logic [1:0] curve_sel;
   logic       frame_err;
   logic       frame_drop;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned q_pix[$];
   int unsigned exp_mean  = 0;
   int unsigned exp_ratio = 0;
   int unsigned exp_sel   = 0;

   always #5 clk = ~clk;

   curve_param_ctrl #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .DARK_TH (DARK_TH),
      .DIV_W   (DIV_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .gray_v      (gray_v),
      .gray_h      (gray_h),
      .gray_de     (gray_de),
      .gray        (gray),
      .param_ready (param_ready),
      .param_valid (param_valid),
      .frame_mean  (frame_mean),
      .dark_ratio  (dark_ratio),
      .curve_sel   (curve_sel),
      .frame_err   (frame_err),
      .frame_drop  (frame_drop)
   );

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Frame-level reference: plain arithmetic over the captured pixel list.
   task automatic model_frame(output int unsigned n, output int unsigned m,
                              output int unsigned r, output int unsigned s);
      int unsigned sum  = 0;
      int unsigned dark = 0;
      n = q_pix.size();
      foreach (q_pix[i]) begin
         sum += q_pix[i];
         if (q_pix[i] < DARK_TH) dark++;
      end
      if (n == 0) begin
         m = 0; r = 0; s = 0;
      end else begin
         m = sum / n;
         if (m > 255) m = 255;
         r = (dark * 256) / n;
         if (r > 255) r = 255;
         if (m < 64 && r >= 128) s = 3;
         else if (m < 96)        s = 2;
         else if (m < 160)       s = 1;
         else                    s = 0;
      end
   endtask

   task automatic send_pixels(input int unsigned count, input int unsigned lo, input int unsigned hi);
      for (int unsigned i = 0; i < count; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            gray_de = 1'b0;
         end
         @(posedge clk); #1;
         gray_de = 1'b1;
         gray_h  = ((i % IMG_W) == 0);
         gray    = 8'($urandom_range(hi, lo));
         q_pix.push_back({24'd0, gray});
      end
      @(posedge clk); #1;
      gray_de = 1'b0;
      gray_h  = 1'b0;
   endtask

   // Rise occurs in the cycle after the first posedge; returns at start of E+1.
   task automatic vsync_pulse();
      @(posedge clk); #1;
      gray_v  = 1'b1;
      gray_de = 1'b0;
      @(posedge clk); #1;
      gray_v = 1'b0;
   endtask

   task automatic handshake();
      @(posedge clk); #1;
      param_ready = 1'b1;
      @(posedge clk); #1;
      param_ready = 1'b0;
      @(negedge clk);
      check_eq("valid_cleared", 32'(param_valid), 0);
   endtask

   task automatic close_frame(input bit armed, input bit accept);
      int unsigned n, m, r, s;
      model_frame(n, m, r, s);
      q_pix.delete();
      vsync_pulse();
      @(negedge clk);
      check_eq("frame_err", 32'(frame_err), 32'(armed && n != 0 && n != FRAME_PIX));
      check_eq("frame_drop_quiet", 32'(frame_drop), 0);
      if (!armed || n == 0) begin
         repeat (70) @(negedge clk);
         check_eq("no_report", 32'(param_valid), 0);
      end else begin
         repeat (64) @(negedge clk);
         check_eq("valid_e65", 32'(param_valid), 0);
         @(negedge clk);
         check_eq("valid_e66", 32'(param_valid), 1);
         check_eq("frame_mean", 32'(frame_mean), m);
         check_eq("dark_ratio", 32'(dark_ratio), r);
         check_eq("curve_sel", 32'(curve_sel), s);
         exp_mean  = m;
         exp_ratio = r;
         exp_sel   = s;
         if (accept) begin
            handshake();
            check_eq("mean_hold", 32'(frame_mean), exp_mean);
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_valid"}, 32'(param_valid), 0);
      check_eq({tag, "_mean"},  32'(frame_mean),  0);
      check_eq({tag, "_ratio"}, 32'(dark_ratio),  0);
      check_eq({tag, "_sel"},   32'(curve_sel),   0);
      check_eq({tag, "_err"},   32'(frame_err),   0);
      check_eq({tag, "_drop"},  32'(frame_drop),  0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Partial frame before the first rise is never reported.
      send_pixels(7, 0, 255);
      close_frame(1'b0, 1'b1);

      send_pixels(FRAME_PIX, 50, 50);
      close_frame(1'b1, 1'b1);

      send_pixels(16, 200, 200);
      send_pixels(16, 10, 10);
      close_frame(1'b1, 1'b1);

      send_pixels(31, 255, 255);
      close_frame(1'b1, 1'b1);

      // Rise while the report is pending: dropped, outputs held.
      send_pixels(FRAME_PIX, 0, 255);
      close_frame(1'b1, 1'b0);
      send_pixels(5, 0, 255);
      q_pix.delete();
      vsync_pulse();
      @(negedge clk);
      check_eq("drop_pulse", 32'(frame_drop), 1);
      check_eq("drop_valid_hold", 32'(param_valid), 1);
      check_eq("drop_mean_hold", 32'(frame_mean), exp_mean);
      check_eq("drop_ratio_hold", 32'(dark_ratio), exp_ratio);
      check_eq("drop_sel_hold", 32'(curve_sel), exp_sel);
      @(negedge clk);
      check_eq("drop_one_cycle", 32'(frame_drop), 0);
      handshake();
      send_pixels(FRAME_PIX, 100, 220);
      close_frame(1'b1, 1'b0);

      // Rise and accept in the same OUT cycle.
      q_pix.delete();
      @(posedge clk); #1;
      gray_v      = 1'b1;
      param_ready = 1'b1;
      @(posedge clk); #1;
      gray_v      = 1'b0;
      param_ready = 1'b0;
      @(negedge clk);
      check_eq("same_cycle_drop", 32'(frame_drop), 1);
      check_eq("same_cycle_valid", 32'(param_valid), 0);
      send_pixels(FRAME_PIX, 200, 200);
      close_frame(1'b1, 1'b1);

      // Reset in the middle of the dark-ratio pass.
      send_pixels(FRAME_PIX, 0, 255);
      q_pix.delete();
      vsync_pulse();
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_pixels(10, 0, 255);
      close_frame(1'b0, 1'b1);
      send_pixels(FRAME_PIX, 0, 120);
      close_frame(1'b1, 1'b1);

      for (int k = 0; k < 8; k++) begin
         int unsigned cnt, lo, hi;
         cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : FRAME_PIX;
         lo  = $urandom_range(0, 200);
         hi  = lo + $urandom_range(0, 55);
         send_pixels(cnt, lo, hi);
         close_frame(1'b1, 1'b1);
      end

      // Frame with no enabled pixels stays silent.
      repeat (10) @(posedge clk);
      close_frame(1'b1, 1'b1);
      send_pixels(FRAME_PIX, 30, 40);
      close_frame(1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
